// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller and CPU/memory arbiter: owns the DMA source register and copies DMA_LEN bytes into OAM.
// Optional feature macro OAM_DMA_RESTART_EN: a source write during a running transfer restarts it.

module oam_dma_ctrl #(
  parameter logic [15:0] DMA_ADDR = 16'hFF46,
  parameter int unsigned DMA_LEN  = 160
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_cpu_rd_addr,
  input  logic        i_cpu_wr_en,
  input  logic [15:0] i_cpu_wr_addr,
  input  logic [7:0]  i_cpu_wr_data,
  output logic [7:0]  o_cpu_rd_data,
  output logic [15:0] o_mem_rd_addr,
  output logic        o_mem_wr_en,
  output logic [15:0] o_mem_wr_addr,
  output logic [7:0]  o_mem_wr_data,
  input  logic [7:0]  i_mem_rd_data,
  output logic        o_dma_active
);

  localparam int unsigned IDX_W = 8;
  localparam int unsigned PH_W  = 2;
  localparam int unsigned DLY_W = 2;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DMA_LEN - 1);
  localparam logic [DLY_W-1:0] LAST_DLY  = DLY_W'(3);
  localparam logic [PH_W-1:0]  PH_READ   = PH_W'(0);
  localparam logic [PH_W-1:0]  PH_WRITE  = PH_W'(1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(3);
  localparam logic [15:0]      HRAM_LO   = 16'hFF80;
  localparam logic [15:0]      HRAM_HI   = 16'hFFFE;
  localparam logic [7:0]       OAM_PAGE  = 8'hFE;
  localparam logic [7:0]       ECHO_BASE = 8'hE0;
  localparam logic [7:0]       ECHO_OFS  = 8'h20;
  localparam logic [7:0]       OPEN_BUS  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_XFER  = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [DLY_W-1:0]   dly_cnt, dly_cnt_nx;
  logic [PH_W-1:0]    phase, phase_nx;
  logic [IDX_W-1:0]   index, index_nx;
  logic [7:0]         src;
  logic [7:0]         src_lat, src_lat_nx;
  logic               dma_active;
  logic               sel_src;
  logic               sel_ff;

  logic               reg_wr;
  logic               reg_rd;
  logic               rd_hram;
  logic               wr_hram;
  logic               busy;
  logic               xfer_rd;
  logic               xfer_wr;

  // Echo RAM pages 0xE0-0xFF alias 0xC0-0xDF.
  function automatic logic [7:0] echo_map(input logic [7:0] page);
    echo_map = (page >= ECHO_BASE) ? page - ECHO_OFS : page;
  endfunction

  always_comb begin
    reg_wr  = i_cpu_wr_en && (i_cpu_wr_addr == DMA_ADDR);
    reg_rd  = (i_cpu_rd_addr == DMA_ADDR);
    rd_hram = (i_cpu_rd_addr >= HRAM_LO) && (i_cpu_rd_addr <= HRAM_HI);
    wr_hram = (i_cpu_wr_addr >= HRAM_LO) && (i_cpu_wr_addr <= HRAM_HI);
    busy    = (state != ST_IDLE);
    xfer_rd = (state == ST_XFER) && (phase == PH_READ);
    xfer_wr = (state == ST_XFER) && (phase == PH_WRITE);
  end

  // State register and per-transfer counters.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= ST_IDLE;
      dly_cnt <= '0;
      phase   <= '0;
      index   <= '0;
      src_lat <= 8'hFF;
    end else begin
      state   <= state_nx;
      dly_cnt <= dly_cnt_nx;
      phase   <= phase_nx;
      index   <= index_nx;
      src_lat <= src_lat_nx;
    end
  end

  // Source register, active flag and read-return select.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      src        <= 8'hFF;
      dma_active <= 1'b0;
      sel_src    <= 1'b0;
      sel_ff     <= 1'b0;
    end else begin
      if (reg_wr) begin
        src <= i_cpu_wr_data;
      end
      dma_active <= (state_nx != ST_IDLE);
      sel_src    <= reg_rd;
      sel_ff     <= busy && (!rd_hram || xfer_rd);
    end
  end

  // Next-state logic: IDLE -> DELAY(4) -> XFER(4 cycles per byte) -> IDLE.
  always_comb begin
    state_nx   = state;
    dly_cnt_nx = dly_cnt;
    phase_nx   = phase;
    index_nx   = index;
    src_lat_nx = src_lat;

    case (state)
      ST_IDLE: begin
        if (reg_wr) begin
          state_nx   = ST_DELAY;
          dly_cnt_nx = '0;
          src_lat_nx = echo_map(i_cpu_wr_data);
        end
      end
      ST_DELAY: begin
        if (dly_cnt == LAST_DLY) begin
          state_nx   = ST_XFER;
          dly_cnt_nx = '0;
          phase_nx   = '0;
          index_nx   = '0;
        end else begin
          dly_cnt_nx = dly_cnt + DLY_W'(1);
        end
      end
      ST_XFER: begin
        phase_nx = phase + PH_W'(1);
        if (phase == PH_LAST) begin
          if (index == LAST_IDX) begin
            state_nx = ST_IDLE;
            index_nx = '0;
          end else begin
            index_nx = index + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

`ifdef OAM_DMA_RESTART_EN
    if (busy && reg_wr) begin
      state_nx   = ST_DELAY;
      dly_cnt_nx = '0;
      phase_nx   = '0;
      index_nx   = '0;
      src_lat_nx = echo_map(i_cpu_wr_data);
    end
`endif
  end

  // Memory port arbitration; the DMA owns the read port in phase 0 and the write port in phase 1.
  always_comb begin
    o_mem_rd_addr = i_cpu_rd_addr;
    o_mem_wr_en   = i_cpu_wr_en && !reg_wr && (!busy || wr_hram);
    o_mem_wr_addr = i_cpu_wr_addr;
    o_mem_wr_data = i_cpu_wr_data;

    if (xfer_rd) begin
      o_mem_rd_addr = {src_lat, index};
    end
    if (xfer_wr) begin
      o_mem_wr_en   = 1'b1;
      o_mem_wr_addr = {OAM_PAGE, index};
      o_mem_wr_data = i_mem_rd_data;
    end
    if (!i_rst) begin
      o_mem_wr_en = 1'b0;
    end
  end

  always_comb begin
    o_cpu_rd_data = i_mem_rd_data;
    if (sel_src) begin
      o_cpu_rd_data = src;
    end else if (sel_ff) begin
      o_cpu_rd_data = OPEN_BUS;
    end
  end

  assign o_dma_active = dma_active;

endmodule
